// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue
//   Instruction queue between Fetch and Decode. It buffers {opcode, pc} uops
//   in a small circular FIFO and presents the oldest one to Decode in
//   first-word fall-through form with a valid/ready handshake. fetch_stall
//   is raised early, so the request Fetch already has in flight still fits.
//   system_flush discards every buffered wrong-path uop.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   uop_valid_in      push request from Fetch, carrying opcode_in / pc_in
//   system_flush      discard all entries (highest priority)
//   dec_ready         Decode accepts the head entry this cycle
//   dec_valid         head entry valid; dec_opcode / dec_pc are zero when empty
//   fetch_stall       registered almost-full backpressure to Fetch
//   count             current occupancy
//   overflow_err      sticky flag: a push was dropped while the queue was full
module fetch_inst_queue #(
    parameter int DEPTH     = 4,
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int AF_MARGIN = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         uop_valid_in,
    input  logic [INST_W-1:0]            opcode_in,
    input  logic [ADDR_W-1:0]            pc_in,
    input  logic                         system_flush,
    input  logic                         dec_ready,
    output logic                         dec_valid,
    output logic [INST_W-1:0]            dec_opcode,
    output logic [ADDR_W-1:0]            dec_pc,
    output logic                         fetch_stall,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    logic [INST_W-1:0] op_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic [CW-1:0] count_next;

    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        pop   = !empty && dec_ready;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push  = uop_valid_in && (!full || pop) && !system_flush;
        drop  = uop_valid_in && full && !pop && !system_flush;

        count_next = count;
        if (system_flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fetch_stall  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (system_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
            count       <= count_next;
            // Tracks post-edge occupancy; held low on flush so Fetch can redirect.
            fetch_stall <= (count_next >= AF_CNT) && !system_flush;
            if (drop)
                overflow_err <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; empty-gating hides stale data.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= opcode_in;
            pc_mem[wr_ptr] <= pc_in;
        end
    end

    always_comb begin
        dec_valid  = !empty;
        dec_opcode = empty ? '0 : op_mem[rd_ptr];
        dec_pc     = empty ? '0 : pc_mem[rd_ptr];
    end

endmodule
